// File: rtl/kfpga_config_loader.sv
// Bitstream loader for the kFPGA configuration chain: clears the chain, then
// serialises valid/ready words LSB-first while checking the chain tail stays 0.
module kfpga_config_loader #(
  parameter int unsigned WORD_WIDTH   = 8,
  parameter int unsigned CHAIN_LENGTH = 4096,
  parameter int unsigned COUNT_WIDTH  = 16,
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   nreset,
  input  logic                   start,
  input  logic [WORD_WIDTH-1:0]  word_data,
  input  logic                   word_valid,
  output logic                   word_ready,
  output logic                   core_config_in,
  output logic                   core_config_enable,
  output logic                   core_config_nreset,
  input  logic                   core_config_out,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] bits_loaded
);

  localparam int unsigned SCNT_W = $clog2(WORD_WIDTH + 1);
  localparam int unsigned CLR_W  = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_t;

  state_t                 state;
  logic [WORD_WIDTH-1:0]  sreg;
  logic [SCNT_W-1:0]      scnt;
  logic [CLR_W-1:0]       clr_cnt;

  logic [COUNT_WIDTH-1:0] bits_next_c;
  logic                   last_shift_c;
  logic                   en_n_c;
  logic                   in_n_c;
  logic [WORD_WIDTH-1:0]  sreg_n_c;
  logic [SCNT_W-1:0]      scnt_n_c;
  logic                   ready_n_c;

  // Next bit to present: remaining register bits first, else a freshly accepted word.
  always_comb begin
    bits_next_c  = bits_loaded + COUNT_WIDTH'(core_config_enable);
    last_shift_c = core_config_enable && (bits_next_c == COUNT_WIDTH'(CHAIN_LENGTH));
    en_n_c       = 1'b0;
    in_n_c       = 1'b0;
    sreg_n_c     = sreg;
    scnt_n_c     = scnt;
    if (scnt != '0) begin
      en_n_c   = 1'b1;
      in_n_c   = sreg[0];
      sreg_n_c = sreg >> 1;
      scnt_n_c = scnt - SCNT_W'(1);
    end else if (word_valid && word_ready) begin
      en_n_c   = 1'b1;
      in_n_c   = word_data[0];
      sreg_n_c = word_data >> 1;
      scnt_n_c = SCNT_W'(WORD_WIDTH - 1);
    end
    // Never ask for a word that could only be discarded after the final bit.
    ready_n_c = (scnt_n_c == '0) &&
                !(en_n_c && ((bits_next_c + COUNT_WIDTH'(1)) == COUNT_WIDTH'(CHAIN_LENGTH)));
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state              <= IDLE;
      sreg               <= '0;
      scnt               <= '0;
      clr_cnt            <= '0;
      word_ready         <= 1'b0;
      core_config_in     <= 1'b0;
      core_config_enable <= 1'b0;
      core_config_nreset <= 1'b1;
      busy               <= 1'b0;
      done               <= 1'b0;
      error              <= 1'b0;
      bits_loaded        <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state              <= CLEAR;
            busy               <= 1'b1;
            done               <= 1'b0;
            error              <= 1'b0;
            bits_loaded        <= '0;
            sreg               <= '0;
            scnt               <= '0;
            clr_cnt            <= '0;
            core_config_nreset <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
            state              <= LOAD;
            core_config_nreset <= 1'b1;
            word_ready         <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + CLR_W'(1);
          end
        end
        LOAD: begin
          bits_loaded <= bits_next_c;
          // The chain was just cleared, so any 1 at the tail means a broken chain.
          if (core_config_enable && core_config_out) begin
            error <= 1'b1;
          end
          if (last_shift_c) begin
            state              <= DONE;
            busy               <= 1'b0;
            done               <= 1'b1;
            core_config_enable <= 1'b0;
            core_config_in     <= 1'b0;
            word_ready         <= 1'b0;
            sreg               <= '0;
            scnt               <= '0;
          end else begin
            core_config_enable <= en_n_c;
            core_config_in     <= in_n_c;
            sreg               <= sreg_n_c;
            scnt               <= scnt_n_c;
            word_ready         <= ready_n_c;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kfpga_config_loader.sv
// Directed bench for kfpga_config_loader with a 10-bit behavioural core chain.
module tb_kfpga_config_loader;

  localparam int unsigned WW = 4;
  localparam int unsigned CL = 10;
  localparam int unsigned CW = 16;
  localparam int unsigned CC = 2;

  logic          clock;
  logic          nreset;
  logic          start;
  logic [WW-1:0] word_data;
  logic          word_valid;
  logic          word_ready;
  logic          cfg_in;
  logic          cfg_en;
  logic          cfg_nreset;
  logic          cfg_out;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] bits_loaded;

  kfpga_config_loader #(
    .WORD_WIDTH(WW), .CHAIN_LENGTH(CL), .COUNT_WIDTH(CW), .CLEAR_CYCLES(CC)
  ) dut (
    .clock(clock), .nreset(nreset), .start(start),
    .word_data(word_data), .word_valid(word_valid), .word_ready(word_ready),
    .core_config_in(cfg_in), .core_config_enable(cfg_en),
    .core_config_nreset(cfg_nreset), .core_config_out(cfg_out),
    .busy(busy), .done(done), .error(error), .bits_loaded(bits_loaded)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Core chain model: cleared by config_nreset, shifts MSB-in on enable.
  logic [CL-1:0] chain;
  int            shift_n;
  logic          fault;
  always @(posedge clock) begin
    if (!cfg_nreset) begin
      chain   <= '0;
      shift_n <= 0;
    end else if (cfg_en) begin
      chain   <= {cfg_in, chain[CL-1:1]};
      shift_n <= shift_n + 1;
    end
  end
  assign cfg_out = chain[0] | (fault && shift_n == 2);

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [WW-1:0] words [3];
  int            r_cyc, r_en, r_gap;
  logic [CL-1:0] r_seq;
  logic          r_frozen_ok, r_ready4, r_err1, r_err3;
  logic [2:0]    r_nrst;

  // Issues start, then feeds the three words until done (or cycle budget).
  task automatic run_load(input int stall_len, input bit pulse_start, input int abort_bits);
    int  idx = 0, stall_cnt = 0, cyc;
    bit  got3 = 0, pulsed = 0, acc;
    r_en = 0; r_gap = 0; r_seq = '0; r_frozen_ok = 1'b1;
    r_ready4 = 1'bx; r_err1 = 1'bx; r_err3 = 1'bx; r_nrst = 3'bxxx;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      if (cyc == 1) r_err1 = error;
      if (cyc <= 3) r_nrst[cyc-1] = cfg_nreset;
      if (abort_bits >= 0 && int'(bits_loaded) == abort_bits) begin
        nreset = 1'b0;
        word_valid = 1'b0;
        tick();
        nreset = 1'b1;
        r_cyc = cyc;
        return;
      end
      if (r_en == 3 && !got3) begin
        r_err3 = error;
        got3 = 1;
      end
      if (cfg_en) begin
        if (r_en == 3) r_ready4 = word_ready;
        if (r_en < int'(CL)) r_seq[r_en] = cfg_in;
        r_en++;
      end else if (r_en > 0) begin
        r_gap++;
        if (bits_loaded != CW'(4)) r_frozen_ok = 1'b0;
      end
      word_valid = (idx < 3) && !(idx == 1 && stall_cnt < stall_len);
      if (idx == 1 && stall_cnt < stall_len && word_ready) stall_cnt++;
      word_data = (idx < 3) ? words[idx] : '0;
      start = pulse_start && r_en == 5 && !pulsed;
      if (start) pulsed = 1;
      acc = word_valid && word_ready;
      tick();
      start = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    word_valid = 1'b0;
    r_cyc = cyc;
  endtask

  localparam logic [CL-1:0] EXP_SEQ = 10'b11_0101_1010;

  initial begin
    words[0] = 4'hA; words[1] = 4'h5; words[2] = 4'h3;
    nreset = 1'b0; start = 1'b0; word_valid = 1'b0; word_data = '0; fault = 1'b0;
    tick();
    tick();
    chk("rst_ready", word_ready, 0);
    chk("rst_in", cfg_in, 0);
    chk("rst_en", cfg_en, 0);
    chk("rst_cnrst", cfg_nreset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_bits", bits_loaded, 0);
    nreset = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    chk("post_rst_cnrst", cfg_nreset, 1);

    // word_valid in IDLE is not accepted
    word_valid = 1'b1; word_data = 4'hF;
    tick();
    chk("idle_ready", word_ready, 0);
    chk("idle_busy", busy, 0);
    word_valid = 1'b0;
    tick();

    // Basic load with back-to-back words
    run_load(0, 0, -1);
    chk("basic_cyc", r_cyc, 14);
    chk("basic_seq", r_seq, EXP_SEQ);
    chk("basic_en_cnt", r_en, 10);
    chk("basic_gap", r_gap, 0);
    chk("b2b_ready4", r_ready4, 1);
    chk("basic_nrst", r_nrst, 3'b100);
    chk("basic_bits", bits_loaded, 10);
    chk("basic_chain", chain, EXP_SEQ);
    chk("basic_err", error, 0);
    chk("basic_busy", busy, 0);
    chk("basic_ready", word_ready, 0);
    word_valid = 1'b1; word_data = 4'hF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("done_en_hold", cfg_en, 0);
      chk("done_in_hold", cfg_in, 0);
      chk("done_flag", done, 1);
    end
    word_valid = 1'b0;
    chk("done_chain_hold", chain, EXP_SEQ);
    chk("done_bits_hold", bits_loaded, 10);

    // Starvation for 5 cycles after the first word
    run_load(5, 0, -1);
    chk("starve_cyc", r_cyc, 19);
    chk("starve_gap", r_gap, 5);
    chk("starve_frozen", r_frozen_ok, 1);
    chk("starve_seq", r_seq, EXP_SEQ);
    chk("starve_chain", chain, EXP_SEQ);
    chk("starve_en_cnt", r_en, 10);

    // Integrity fault on the third shift
    fault = 1'b1;
    run_load(0, 0, -1);
    fault = 1'b0;
    chk("fault_err_after3", r_err3, 1);
    chk("fault_err_done", error, 1);
    chk("fault_done", done, 1);
    chk("fault_cyc", r_cyc, 14);

    // Restart clears error; start during LOAD ignored
    run_load(0, 1, -1);
    chk("restart_err_clr", r_err1, 0);
    chk("clean_err_after3", r_err3, 0);
    chk("pulse_cyc", r_cyc, 14);
    chk("pulse_en_cnt", r_en, 10);
    chk("pulse_seq", r_seq, EXP_SEQ);
    chk("pulse_err", error, 0);

    // Reset mid-load at bits_loaded = 6
    run_load(0, 0, 6);
    chk("abort_busy", busy, 0);
    chk("abort_en", cfg_en, 0);
    chk("abort_cnrst", cfg_nreset, 1);
    chk("abort_bits", bits_loaded, 0);
    chk("abort_ready", word_ready, 0);
    tick();
    run_load(0, 0, -1);
    chk("reload_nrst", r_nrst, 3'b100);
    chk("reload_cyc", r_cyc, 14);
    chk("reload_chain", chain, EXP_SEQ);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
